// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store units, the port arbiter and the unified memory.
// slave is the arbiter's view; master is the view of the surrounding units and memory.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [BE_W-1:0]   dm_be;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              bus_err;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata,
        output busy, bus_err
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata,
        input  busy, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the load/store path,
// one outstanding transaction at a time. Define ARB_TIMEOUT_EN to abort unacknowledged requests.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);
    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned SC_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        DM_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("mem_port_arbiter: STARVE_MAX must be 1..15");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT must be at least 1");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SC_W-1:0]   r_starve_cnt;
    logic              w_starved;
    logic              w_gnt_if;
    logic              w_gnt_dm;
    logic              w_done;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [BE_W-1:0]   r_mem_be;
    logic              r_if_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_dm_rvalid;
    logic [DATA_W-1:0] r_dm_rdata;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]   r_to_cnt;
    logic              w_to_expired;
    logic              w_abort;
    logic              r_bus_err;

    assign w_to_expired = (r_to_cnt == TO_W'(TIMEOUT - 1));
`endif

    assign w_starved = (r_starve_cnt == SC_W'(STARVE_MAX));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration and transaction sequencing; DM wins contests unless IF has been starved
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_if    = 1'b0;
        w_gnt_dm    = 1'b0;
        w_done      = 1'b0;
`ifdef ARB_TIMEOUT_EN
        w_abort     = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (bus.dm_req && !(bus.if_req && w_starved)) begin
                    w_gnt_dm    = 1'b1;
                    w_state_nxt = DM_WAIT;
                end else if (bus.if_req) begin
                    w_gnt_if    = 1'b1;
                    w_state_nxt = IF_WAIT;
                end
            end
            IF_WAIT, DM_WAIT: begin
                if (bus.mem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (w_to_expired) begin
                    w_abort     = 1'b1;
                    w_state_nxt = RESP;
                end
`endif
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Contested DM wins count toward forcing IF through; any IF grant clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_gnt_if) begin
            r_starve_cnt <= '0;
        end else if (w_gnt_dm && bus.if_req && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + SC_W'(1);
        end
    end

    // Memory command latch and response return to the owner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rvalid <= 1'b0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            if (w_gnt_if) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= bus.if_addr;
                r_mem_be   <= '1;
            end else if (w_gnt_dm) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= bus.dm_we;
                r_mem_addr  <= bus.dm_addr;
                r_mem_wdata <= bus.dm_wdata;
                r_mem_be    <= bus.dm_be;
            end
            if (w_done) begin
                r_mem_req <= 1'b0;
                if (r_state == IF_WAIT) begin
                    r_if_rvalid <= 1'b1;
                    r_if_rdata  <= bus.mem_rdata;
                end else begin
                    r_dm_rvalid <= 1'b1;
                    if (!r_mem_we) begin
                        r_dm_rdata <= bus.mem_rdata;
                    end
                end
            end
`ifdef ARB_TIMEOUT_EN
            if (w_abort) begin
                r_mem_req <= 1'b0;
                if (r_state == IF_WAIT) begin
                    r_if_rvalid <= 1'b1;
                    r_if_rdata  <= '0;
                end else begin
                    r_dm_rvalid <= 1'b1;
                    r_dm_rdata  <= '0;
                end
            end
`endif
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Counts consecutive unacknowledged request cycles of the current transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt  <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_abort;
            if ((r_state == IF_WAIT || r_state == DM_WAIT) && w_state_nxt == r_state) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign bus.bus_err = r_bus_err;
`else
    assign bus.bus_err = 1'b0;
`endif

    assign bus.if_gnt    = rst_n & w_gnt_if;
    assign bus.dm_gnt    = rst_n & w_gnt_dm;
    assign bus.if_rvalid = r_if_rvalid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rvalid = r_dm_rvalid;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_be    = r_mem_be;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table of single transactions, a response
// scoreboard, and hand sequences for contest, starvation, ignored ack, timeout and reset.
module tb_mem_port_arbiter;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned TIMEOUT    = 8;

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;
        logic [31:0] mrd;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        is_dm;
        logic [31:0] rdata;
        logic        err;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_bad = 0;
    int   cyc = 0;
    sb_t  sb_q[$];

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one cycle; any response seen is matched against the scoreboard head
    task automatic tick();
        sb_t e;
        @(negedge clk);
        cyc++;
        if (bus.if_rvalid || bus.dm_rvalid || bus.bus_err) begin
            if (sb_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL sb_unexpected: if_rvalid=%b dm_rvalid=%b bus_err=%b with nothing expected (cycle %0d)",
                         bus.if_rvalid, bus.dm_rvalid, bus.bus_err, cyc);
            end else begin
                e = sb_q.pop_front();
                chk1("sb_if_rvalid", bus.if_rvalid, !e.is_dm);
                chk1("sb_dm_rvalid", bus.dm_rvalid, e.is_dm);
                chk1("sb_bus_err", bus.bus_err, e.err);
                chk("sb_rdata", e.is_dm ? bus.dm_rdata : bus.if_rdata, e.rdata);
            end
        end
    endtask

    task automatic do_txn(input vec_t v);
        sb_t e;
        if (v.is_dm) begin
            bus.dm_req   = 1'b1;
            bus.dm_we    = v.we;
            bus.dm_addr  = v.addr;
            bus.dm_wdata = v.wdata;
            bus.dm_be    = v.be;
        end else begin
            bus.if_req  = 1'b1;
            bus.if_addr = v.addr;
        end
        #1;
        chk1("txn_if_gnt", bus.if_gnt, !v.is_dm);
        chk1("txn_dm_gnt", bus.dm_gnt, v.is_dm);
        e.is_dm = v.is_dm;
        e.rdata = v.exp_rdata;
        e.err   = 1'b0;
        sb_q.push_back(e);
        tick();
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        chk1("txn_mem_req", bus.mem_req, 1'b1);
        chk("txn_mem_addr", bus.mem_addr, v.addr);
        chk1("txn_mem_we", bus.mem_we, v.exp_we);
        chk("txn_mem_be", 32'(bus.mem_be), 32'(v.exp_be));
        if (v.exp_we) chk("txn_mem_wdata", bus.mem_wdata, v.wdata);
        chk1("txn_busy", bus.busy, 1'b1);
        for (int k = 1; k < v.lat; k++) begin
            tick();
            chk1("txn_mem_req_hold", bus.mem_req, 1'b1);
            chk("txn_mem_addr_hold", bus.mem_addr, v.addr);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = v.mrd;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        chk1("txn_rvalid", v.is_dm ? bus.dm_rvalid : bus.if_rvalid, 1'b1);
        chk1("txn_mem_req_off", bus.mem_req, 1'b0);
        tick();
        chk1("txn_rvalid_single", bus.if_rvalid | bus.dm_rvalid, 1'b0);
        chk1("txn_busy_idle", bus.busy, 1'b0);
        chk("txn_sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    // One arbitration with requests already set up; memory acks immediately
    task automatic arb_round(input logic exp_dm, input logic [31:0] mrd, input int exp_cnt,
                             input logic drop_dm, input logic drop_if);
        sb_t e;
        #1;
        chk1("arb_dm_gnt", bus.dm_gnt, exp_dm);
        chk1("arb_if_gnt", bus.if_gnt, !exp_dm);
        e.is_dm = exp_dm;
        e.rdata = mrd;
        e.err   = 1'b0;
        sb_q.push_back(e);
        tick();
        if (drop_dm) bus.dm_req = 1'b0;
        if (drop_if) bus.if_req = 1'b0;
        chk("arb_starve_cnt", 32'(dut.r_starve_cnt), 32'(exp_cnt));
        chk("arb_mem_addr", bus.mem_addr, exp_dm ? 32'h0000_0800 : 32'h0000_0400);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mrd;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        tick();
    endtask

    initial begin
        vec_t vecs[6];
        sb_t  e;
        int   n_hi;
        logic all_hi;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 2, 32'h0050_0093, 1'b0, 4'hF, 32'h0050_0093};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'hF, 1, 32'h1234_5678, 1'b0, 4'hF, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'h3, 1, 32'hFFFF_FFFF, 1'b1, 4'h3, 32'h1234_5678};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_2004, 32'h0BAD_F00D, 4'h0, 3, 32'hA5A5_A5A5, 1'b1, 4'h0, 32'h1234_5678};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 1, 32'hCAFE_F00D, 1'b0, 4'hF, 32'hCAFE_F00D};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_3004, 32'h0, 4'h1, 4, 32'h0000_00A5, 1'b0, 4'h1, 32'h0000_00A5};

        bus.if_req = 1'b1; bus.if_addr = '0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_be = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;

        // Reset state, grants gated off even with both requests raised
        tick();
        tick();
        chk1("rst_if_gnt", bus.if_gnt, 1'b0);
        chk1("rst_dm_gnt", bus.dm_gnt, 1'b0);
        chk1("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_bus_err", bus.bus_err, 1'b0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_dm_rdata", bus.dm_rdata, 32'h0);
        chk("rst_starve_cnt", 32'(dut.r_starve_cnt), 32'd0);
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) do_txn(vecs[i]);

        // Ack while idle must be ignored
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_0055;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        tick();
        chk1("idle_ack_mem_req", bus.mem_req, 1'b0);
        chk1("idle_ack_busy", bus.busy, 1'b0);
        chk("idle_ack_if_rdata", bus.if_rdata, 32'hCAFE_F00D);
        chk("idle_ack_dm_rdata", bus.dm_rdata, 32'h0000_00A5);

        // Contest: DM first, IF in the next idle cycle
        bus.if_addr = 32'h0000_0400;
        bus.dm_addr = 32'h0000_0800;
        bus.dm_we   = 1'b0;
        bus.dm_be   = 4'hF;
        bus.if_req  = 1'b1;
        bus.dm_req  = 1'b1;
        arb_round(1'b1, 32'h1111_1111, 1, 1'b1, 1'b0);
        arb_round(1'b0, 32'h2222_2222, 0, 1'b0, 1'b1);

        // Starvation: four DM wins, fifth arbitration goes to IF
        bus.if_req = 1'b1;
        bus.dm_req = 1'b1;
        for (int i = 1; i <= 4; i++) arb_round(1'b1, 32'h3000_0000 + 32'(i), i, 1'b0, 1'b0);
        arb_round(1'b0, 32'h4444_4444, 0, 1'b1, 1'b1);
        chk1("starve_busy_idle", bus.busy, 1'b0);
        chk("starve_dm_rdata", bus.dm_rdata, 32'h3000_0004);

        // Unacknowledged fetch
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0200;
        #1;
        chk1("noack_if_gnt", bus.if_gnt, 1'b1);
`ifdef ARB_TIMEOUT_EN
        e.is_dm = 1'b0;
        e.rdata = 32'h0;
        e.err   = 1'b1;
        sb_q.push_back(e);
`endif
        tick();
        bus.if_req = 1'b0;
`ifdef ARB_TIMEOUT_EN
        n_hi = 0;
        while (bus.mem_req && n_hi < 20) begin
            n_hi++;
            tick();
        end
        chk("to_mem_req_cycles", 32'(n_hi), 32'(TIMEOUT));
        chk1("to_bus_err", bus.bus_err, 1'b1);
        chk1("to_if_rvalid", bus.if_rvalid, 1'b1);
        chk("to_if_rdata", bus.if_rdata, 32'h0);
        tick();
        chk1("to_busy_idle", bus.busy, 1'b0);
        chk1("to_bus_err_pulse", bus.bus_err, 1'b0);
`else
        all_hi = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (!bus.mem_req || bus.bus_err) all_hi = 1'b0;
            tick();
        end
        chk1("noack_waits", all_hi & bus.mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("noack_rst_mem_req", bus.mem_req, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk1("noack_rst_busy", bus.busy, 1'b0);
`endif

        // Reset during DM_WAIT with an ack arriving inside reset
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h0000_0900;
        #1;
        chk1("mrst_dm_gnt", bus.dm_gnt, 1'b1);
        tick();
        bus.dm_req = 1'b0;
        chk1("mrst_mem_req_before", bus.mem_req, 1'b1);
        #2;
        rst_n         = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        bus.if_req    = 1'b1;
        #1;
        chk1("mrst_mem_req_async", bus.mem_req, 1'b0);
        chk1("mrst_busy", bus.busy, 1'b0);
        chk1("mrst_if_gnt_gated", bus.if_gnt, 1'b0);
        tick();
        tick();
        rst_n       = 1'b1;
        bus.mem_ack = 1'b0;
        bus.if_req  = 1'b0;
        repeat (3) tick();
        chk1("mrst_busy_after", bus.busy, 1'b0);
        chk1("mrst_mem_req_after", bus.mem_req, 1'b0);
        chk("mrst_dm_rdata", bus.dm_rdata, 32'h0);
        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

endmodule
